// File: rtl/pir_motion_ctrl.sv
// PIR motion controller: synchronizes and debounces the Pmod PIR output, sequences
// warm-up / idle / active / hold, counts motion events and frame-aligns the motion flag.
module pir_motion_ctrl #(
    parameter int WARMUP_CYCLES   = 300_000_000,
    parameter int HOLD_CYCLES     = 300_000_000,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic        clk_148_mhz,
    input  logic        rst_n,
    input  logic        pir_in,
    input  logic        frame_start,
    input  logic        arm,
    input  logic        clear_count,
    output logic        motion_active,
    output logic        sensor_ready,
    output logic [1:0]  state,
    output logic        event_pulse,
    output logic [15:0] event_count
);

    localparam logic [1:0] WARMUP = 2'd0;
    localparam logic [1:0] IDLE   = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic [31:0] WARMUP_LAST   = 32'(WARMUP_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST     = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] DEBOUNCE_LAST = 32'(DEBOUNCE_CYCLES - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        pir_sync_p0;
    logic        pir_sync_p1;
    logic        pir_s;
    logic        pir_db;
    logic [31:0] db_cnt;
    logic [31:0] warm_cnt;
    logic [31:0] hold_cnt;
    logic [1:0]  state_nxt;
    logic        new_event;

    assign pir_s = pir_sync_p1;

    // Stage p0/p1: two-flop synchronizer, then the debouncer
    always_ff @(posedge clk_148_mhz or negedge rst_n) begin
        if (!rst_n) begin
            pir_sync_p0 <= 1'b0;
            pir_sync_p1 <= 1'b0;
            pir_db      <= 1'b0;
            db_cnt      <= '0;
        end else begin
            pir_sync_p0 <= pir_in;
            pir_sync_p1 <= pir_sync_p0;
            if (pir_s != pir_db) begin
                if (db_cnt == DEBOUNCE_LAST) begin
                    pir_db <= pir_s;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 32'd1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Disarming overrides every other transition once an event is in progress
    always_comb begin
        state_nxt = state;
        new_event = 1'b0;
        case (state)
            WARMUP: begin
                if (warm_cnt == WARMUP_LAST) state_nxt = IDLE;
            end
            IDLE: begin
                if (arm && pir_db) begin
                    state_nxt = ACTIVE;
                    new_event = 1'b1;
                end
            end
            ACTIVE: begin
                if (!arm)        state_nxt = IDLE;
                else if (!pir_db) state_nxt = HOLD;
            end
            default: begin
                if (!arm)                       state_nxt = IDLE;
                else if (pir_db)                state_nxt = ACTIVE;
                else if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_148_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WARMUP;
            warm_cnt      <= '0;
            hold_cnt      <= '0;
            sensor_ready  <= 1'b0;
            event_pulse   <= 1'b0;
            event_count   <= '0;
            motion_active <= 1'b0;
        end else begin
            state       <= state_nxt;
            event_pulse <= new_event;
            if (state == WARMUP) begin
                warm_cnt <= warm_cnt + 32'd1;
                if (state_nxt == IDLE) sensor_ready <= 1'b1;
            end
            // Held at zero outside HOLD so every HOLD entry starts from 0
            if (state == HOLD) hold_cnt <= hold_cnt + 32'd1;
            else               hold_cnt <= '0;
            if (new_event)        event_count <= clear_count ? 16'd1 : sat_inc(event_count);
            else if (clear_count) event_count <= '0;
            // Colour only changes between frames
            if (frame_start) motion_active <= (state == ACTIVE) || (state == HOLD);
        end
    end

endmodule

// File: tb/tb_pir_motion_ctrl.sv
// Bench for pir_motion_ctrl: directed scenario tasks plus a randomized run compared
// cycle by cycle against a behavioural model of the controller.
module tb_pir_motion_ctrl;

    localparam int WARM = 16;
    localparam int HOLDC = 32;
    localparam int DEB = 4;

    logic        clk_148_mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        pir_in = 1'b0;
    logic        frame_start = 1'b0;
    logic        arm = 1'b0;
    logic        clear_count = 1'b0;
    logic        motion_active;
    logic        sensor_ready;
    logic [1:0]  state;
    logic        event_pulse;
    logic [15:0] event_count;

    int n_checks = 0;
    int n_err = 0;

    pir_motion_ctrl #(
        .WARMUP_CYCLES  (WARM),
        .HOLD_CYCLES    (HOLDC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_148_mhz  (clk_148_mhz),
        .rst_n        (rst_n),
        .pir_in       (pir_in),
        .frame_start  (frame_start),
        .arm          (arm),
        .clear_count  (clear_count),
        .motion_active(motion_active),
        .sensor_ready (sensor_ready),
        .state        (state),
        .event_pulse  (event_pulse),
        .event_count  (event_count)
    );

    always #5 clk_148_mhz = ~clk_148_mhz;

    // Behavioural model: tracks elapsed clocks per phase rather than counter values
    typedef struct packed {
        int   st;
        int   since;
        int   hold_n;
        int   db_run;
        int   count;
        logic s1;
        logic s2;
        logic db;
        logic ready;
        logic pulse;
        logic motion;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t c, logic pir, logic a, logic fs, logic clr);
        model_t n;
        n = c;
        n.pulse = 1'b0;
        if (fs) n.motion = (c.st == 2 || c.st == 3);
        case (c.st)
            0: begin
                n.since = c.since + 1;
                if (n.since == WARM) begin n.st = 1; n.ready = 1'b1; end
            end
            1: if (a && c.db) begin n.st = 2; n.pulse = 1'b1; end
            2: begin
                if (!a) n.st = 1;
                else if (!c.db) begin n.st = 3; n.hold_n = 0; end
            end
            default: begin
                if (!a) n.st = 1;
                else if (c.db) n.st = 2;
                else begin
                    n.hold_n = c.hold_n + 1;
                    if (n.hold_n == HOLDC) n.st = 1;
                end
            end
        endcase
        if (n.pulse) n.count = clr ? 1 : ((c.count < 65535) ? c.count + 1 : 65535);
        else if (clr) n.count = 0;
        if (c.s2 != c.db) begin
            n.db_run = c.db_run + 1;
            if (n.db_run == DEB) begin n.db = c.s2; n.db_run = 0; end
        end else begin
            n.db_run = 0;
        end
        n.s2 = c.s1;
        n.s1 = pir;
        return n;
    endfunction

    always @(posedge clk_148_mhz or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= model_next(m, pir_in, arm, frame_start, clear_count);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_148_mhz);
    endtask

    task automatic apply_reset(input logic p, input logic a);
        @(negedge clk_148_mhz);
        rst_n = 1'b0; pir_in = p; arm = a; frame_start = 1'b0; clear_count = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_148_mhz);
        rst_n = 1'b0; pir_in = 1'b1; arm = 1'b1; frame_start = 1'b1; clear_count = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({state, sensor_ready, event_pulse, motion_active, event_count} !== 21'd0) begin
                n_err++;
                $display("FAIL reset cyc%0d: state=%0d ready=%b pulse=%b motion=%b count=%0d, required all 0",
                         k, state, sensor_ready, event_pulse, motion_active, event_count);
            end
        end
        frame_start = 1'b0;
    endtask

    task automatic test_warmup();
        apply_reset(1'b1, 1'b1);
        for (int k = 1; k <= WARM; k++) begin
            tick();
            n_checks++;
            if (state !== ((k == WARM) ? 2'd1 : 2'd0) || sensor_ready !== (k == WARM)) begin
                n_err++;
                $display("FAIL warmup clk%0d: state=%0d ready=%b, required state=%0d ready=%b",
                         k, state, sensor_ready, (k == WARM) ? 1 : 0, (k == WARM));
            end
        end
        tick();
        n_checks++;
        if (state !== 2'd2 || event_pulse !== 1'b1 || event_count !== 16'd1) begin
            n_err++;
            $display("FAIL first_event: state=%0d pulse=%b count=%0d, required 2 1 1", state, event_pulse, event_count);
        end
        tick();
        n_checks++;
        if (state !== 2'd2 || event_pulse !== 1'b0 || event_count !== 16'd1) begin
            n_err++;
            $display("FAIL event_one_shot: state=%0d pulse=%b count=%0d, required 2 0 1", state, event_pulse, event_count);
        end
    endtask

    task automatic test_glitch();
        apply_reset(1'b0, 1'b1);
        tick(WARM + 4);
        pir_in = 1'b1;
        tick(3);
        pir_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (state !== 2'd1 || event_pulse !== 1'b0 || event_count !== 16'd0) begin
                n_err++;
                $display("FAIL glitch cyc%0d: state=%0d pulse=%b count=%0d, required 1 0 0", k, state, event_pulse, event_count);
            end
        end
    endtask

    task automatic test_hold();
        apply_reset(1'b1, 1'b1);
        tick(WARM + 1);
        pir_in = 1'b0;
        for (int k = 1; k <= DEB + 3; k++) begin
            tick();
            n_checks++;
            if (state !== ((k == DEB + 3) ? 2'd3 : 2'd2)) begin
                n_err++;
                $display("FAIL hold_entry clk%0d: state=%0d, required %0d", k, state, (k == DEB + 3) ? 3 : 2);
            end
        end
        tick(4);
        pir_in = 1'b1;
        for (int k = 1; k <= DEB + 3; k++) begin
            tick();
            n_checks++;
            if (state !== ((k == DEB + 3) ? 2'd2 : 2'd3) || event_pulse !== 1'b0 || event_count !== 16'd1) begin
                n_err++;
                $display("FAIL hold_return clk%0d: state=%0d pulse=%b count=%0d, required %0d 0 1",
                         k, state, event_pulse, event_count, (k == DEB + 3) ? 2 : 3);
            end
        end
        pir_in = 1'b0;
        tick(DEB + 3);
        n_checks++;
        if (state !== 2'd3) begin
            n_err++;
            $display("FAIL hold_reentry: state=%0d, required 3", state);
        end
        for (int k = 1; k <= HOLDC; k++) begin
            tick();
            n_checks++;
            if (state !== ((k == HOLDC) ? 2'd1 : 2'd3) || event_pulse !== 1'b0) begin
                n_err++;
                $display("FAIL hold_expire clk%0d: state=%0d pulse=%b, required %0d 0",
                         k, state, event_pulse, (k == HOLDC) ? 1 : 3);
            end
        end
    endtask

    task automatic test_frame_align();
        apply_reset(1'b1, 1'b1);
        tick(WARM + 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (state !== 2'd2 || motion_active !== 1'b0) begin
                n_err++;
                $display("FAIL frame_wait cyc%0d: state=%0d motion=%b, required 2 0", k, state, motion_active);
            end
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_checks++;
        if (motion_active !== 1'b1) begin
            n_err++;
            $display("FAIL frame_load: motion=%b, required 1", motion_active);
        end
        arm = 1'b0;
        tick(3);
        n_checks++;
        if (state !== 2'd1 || motion_active !== 1'b1) begin
            n_err++;
            $display("FAIL frame_hold: state=%0d motion=%b, required 1 1", state, motion_active);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n_checks++;
        if (motion_active !== 1'b0) begin
            n_err++;
            $display("FAIL frame_clear: motion=%b, required 0", motion_active);
        end
    endtask

    task automatic test_saturate();
        apply_reset(1'b1, 1'b1);
        tick(WARM + 1);
        arm = 1'b0;
        tick();
        // Preload close to the top rather than spending 65534 event cycles
        force dut.event_count = 16'hFFFE;
        #1;
        release dut.event_count;
        arm = 1'b1;
        tick();
        n_checks++;
        if (event_count !== 16'hFFFF || event_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL sat_reach: count=%h pulse=%b, required ffff 1", event_count, event_pulse);
        end
        arm = 1'b0;
        tick();
        arm = 1'b1;
        tick();
        n_checks++;
        if (event_count !== 16'hFFFF || event_pulse !== 1'b1 || state !== 2'd2) begin
            n_err++;
            $display("FAIL sat_hold: count=%h pulse=%b state=%0d, required ffff 1 2", event_count, event_pulse, state);
        end
        arm = 1'b0;
        tick();
        arm = 1'b1;
        clear_count = 1'b1;
        tick();
        n_checks++;
        if (event_count !== 16'd1 || event_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL clear_with_event: count=%h pulse=%b, required 0001 1", event_count, event_pulse);
        end
        clear_count = 1'b0;
        arm = 1'b0;
        tick();
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        n_checks++;
        if (event_count !== 16'd0) begin
            n_err++;
            $display("FAIL clear_alone: count=%h, required 0000", event_count);
        end
    endtask

    task automatic test_arm_and_reset();
        apply_reset(1'b1, 1'b1);
        tick(WARM + 1);
        pir_in = 1'b0;
        tick(DEB + 5);
        n_checks++;
        if (state !== 2'd3) begin
            n_err++;
            $display("FAIL disarm_pre: state=%0d, required 3", state);
        end
        arm = 1'b0;
        tick();
        n_checks++;
        if (state !== 2'd1) begin
            n_err++;
            $display("FAIL disarm_hold: state=%0d, required 1", state);
        end
        arm = 1'b1;
        pir_in = 1'b1;
        tick(DEB + 3);
        n_checks++;
        if (state !== 2'd2 || event_count !== 16'd2) begin
            n_err++;
            $display("FAIL rearm: state=%0d count=%0d, required 2 2", state, event_count);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({state, sensor_ready, event_pulse, motion_active, event_count} !== 21'd0) begin
            n_err++;
            $display("FAIL async_reset: state=%0d ready=%b pulse=%b motion=%b count=%0d, required all 0",
                     state, sensor_ready, event_pulse, motion_active, event_count);
        end
        @(negedge clk_148_mhz);
        rst_n = 1'b1;
        tick(WARM - 1);
        n_checks++;
        if (state !== 2'd0 || sensor_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rewarm_pre: state=%0d ready=%b, required 0 0", state, sensor_ready);
        end
        tick();
        n_checks++;
        if (state !== 2'd1 || sensor_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rewarm_done: state=%0d ready=%b, required 1 1", state, sensor_ready);
        end
    endtask

    task automatic test_random();
        logic [20:0] got;
        logic [20:0] want;
        apply_reset(1'b0, 1'b1);
        for (int k = 0; k < 4000; k++) begin
            tick();
            got  = {state, sensor_ready, event_pulse, motion_active, event_count};
            want = {2'(m.st), m.ready, m.pulse, m.motion, 16'(m.count)};
            n_checks++;
            if (got !== want) begin
                n_err++;
                $display("FAIL random cyc%0d: {state,ready,pulse,motion,count}=%h, required %h", k, got, want);
            end
            rst_n       = ($urandom_range(0, 1499) != 0);
            if ($urandom_range(0, 11) == 0) pir_in = ~pir_in;
            if ($urandom_range(0, 39) == 0) arm = ~arm;
            else if (!arm && $urandom_range(0, 3) == 0) arm = 1'b1;
            frame_start = ($urandom_range(0, 29) == 0);
            clear_count = ($urandom_range(0, 59) == 0);
        end
        rst_n = 1'b1;
        frame_start = 1'b0;
        clear_count = 1'b0;
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_glitch();
        test_hold();
        test_frame_align();
        test_saturate();
        test_arm_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
